// File: rtl/ula_pkg.sv
// ============================================================================
// Module      : ula_pkg
// Description : Shared opcode, FSM state and flag types for the sequential ULA.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ula_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_MUL = 3'b110,
    OP_CLR = 3'b111
  } opcode_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  typedef struct packed {
    logic o;
    logic c;
    logic z;
    logic n;
  } flags_t;

endpackage

`default_nettype wire

// File: rtl/ula_core.sv
// ============================================================================
// Module      : ula_core
// Description : Combinational single-cycle ALU ops (AND/OR/ADD/SUB/XOR/SHL/CLR).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ula_core
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  opcode_e          i_opcode,
  output logic [WIDTH-1:0] o_result,
  output flags_t           o_flags
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_shl;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_result;
  logic             w_o;
  logic             w_c;

  assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
  assign w_shamt = i_b[SHW-1:0];
  // Bit WIDTH of the extended shift is A[WIDTH-shamt], and stays 0 for shamt=0.
  assign w_shl   = {1'b0, i_a} << w_shamt;

  always_comb begin
    w_result = '0;
    w_o      = 1'b0;
    w_c      = 1'b0;
    case (i_opcode)
      OP_AND: w_result = i_a & i_b;
      OP_OR:  w_result = i_a | i_b;
      OP_XOR: w_result = i_a ^ i_b;
      OP_ADD: begin
        w_result = w_sum[WIDTH-1:0];
        w_c      = w_sum[WIDTH];
        w_o      = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_result = w_diff[WIDTH-1:0];
        w_c      = w_diff[WIDTH];
        w_o      = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SHL: begin
        w_result = w_shl[WIDTH-1:0];
        w_c      = w_shl[WIDTH];
      end
      default: w_result = '0;
    endcase
  end

  assign o_result = w_result;
  assign o_flags  = '{o: w_o, c: w_c, z: ~|w_result, n: w_result[WIDTH-1]};

endmodule

`default_nettype wire

// File: rtl/ula_seq.sv
// ============================================================================
// Module      : ula_seq
// Description : Registered, handshaked ALU with accumulator, O/C/Z/N flags and
//               a WIDTH-cycle shift-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ula_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  input  logic             use_acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Saida,
  output logic             FLAG_O,
  output logic             FLAG_C,
  output logic             FLAG_Z,
  output logic             FLAG_N
);

  localparam int             SHW    = $clog2(WIDTH);
  localparam logic [SHW-1:0] C_LAST = SHW'(WIDTH - 1);

  state_e             state_q,  state_d;
  logic [WIDTH-1:0]   saida_q,  saida_d;
  flags_t             flags_q,  flags_d;
  logic               done_q,   done_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [2*WIDTH-1:0] prod_q,   prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SHW-1:0]     cnt_q,    cnt_d;

  opcode_e            w_op;
  logic [WIDTH-1:0]   w_a_op;
  logic [WIDTH-1:0]   w_core_result;
  flags_t             w_core_flags;
  logic [2*WIDTH-1:0] w_step_prod;

  assign w_op   = opcode_e'(opcode);
  assign w_a_op = use_acc ? saida_q : A;

  ula_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_a      (w_a_op),
    .i_b      (B),
    .i_opcode (w_op),
    .o_result (w_core_result),
    .o_flags  (w_core_flags)
  );

  assign w_step_prod = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    saida_d  = saida_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (w_op == OP_MUL) begin
            state_d  = MUL;
            mcand_d  = {{WIDTH{1'b0}}, w_a_op};
            mplier_d = B;
            prod_d   = '0;
            cnt_d    = '0;
          end else begin
            saida_d = w_core_result;
            flags_d = w_core_flags;
            done_d  = 1'b1;
          end
        end
      end
      MUL: begin
        // One multiplier bit per cycle, LSB first; result lands on the last step.
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        prod_d   = w_step_prod;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == C_LAST) begin
          state_d = IDLE;
          saida_d = w_step_prod[WIDTH-1:0];
          flags_d = '{o: |w_step_prod[2*WIDTH-1:WIDTH],
                      c: 1'b0,
                      z: ~|w_step_prod[WIDTH-1:0],
                      n: w_step_prod[WIDTH-1]};
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      saida_q  <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      saida_q  <= saida_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = (state_q == MUL);
  assign done   = done_q;
  assign Saida  = saida_q;
  assign FLAG_O = flags_q.o;
  assign FLAG_C = flags_q.c;
  assign FLAG_Z = flags_q.z;
  assign FLAG_N = flags_q.n;

endmodule

`default_nettype wire

// File: tb/tb_ula_seq.sv
// ============================================================================
// Module      : tb_ula_seq
// Description : Self-checking bench for ula_seq (WIDTH=8) against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ula_seq;
  import ula_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   opcode;
  logic         use_acc;
  logic         busy;
  logic         done;
  logic [W-1:0] Saida;
  logic         FLAG_O;
  logic         FLAG_C;
  logic         FLAG_Z;
  logic         FLAG_N;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] acc;

  ula_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .A       (A),
    .B       (B),
    .opcode  (opcode),
    .use_acc (use_acc),
    .busy    (busy),
    .done    (done),
    .Saida   (Saida),
    .FLAG_O  (FLAG_O),
    .FLAG_C  (FLAG_C),
    .FLAG_Z  (FLAG_Z),
    .FLAG_N  (FLAG_N)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {O, C, Z, N, result} computed with plain integer arithmetic.
  function automatic logic [11:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, sa, sb, full, r, sh;
    bit o, c;
    ia = int'(a);
    ib = int'(b);
    sa = (ia > 127) ? ia - 256 : ia;
    sb = (ib > 127) ? ib - 256 : ib;
    o = 1'b0;
    c = 1'b0;
    r = 0;
    case (op)
      OP_AND: r = ia & ib;
      OP_OR:  r = ia | ib;
      OP_XOR: r = ia ^ ib;
      OP_ADD: begin
        full = ia + ib;
        r = full % 256;
        c = (full > 255);
        o = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      OP_SUB: begin
        r = (ia - ib + 256) % 256;
        c = (ia < ib);
        o = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      OP_SHL: begin
        sh = ib % 8;
        full = ia << sh;
        r = full % 256;
        c = (sh != 0) && (((full >> 8) % 2) == 1);
      end
      OP_MUL: begin
        full = ia * ib;
        r = full % 256;
        o = (full > 255);
      end
      default: r = 0;
    endcase
    return {o, c, (r == 0), (r > 127), 8'(r)};
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ua, input bit poke);
    logic [11:0] e;
    int n;
    e = model(op, ua ? acc : a, b);
    start   = 1'b1;
    opcode  = op;
    A       = a;
    B       = b;
    use_acc = ua;
    tick();
    start = 1'b0;
    if (op == OP_MUL) begin
      n = 0;
      while (done !== 1'b1 && n < 3 * W) begin
        check("mul_busy", 16'(busy), 16'd1);
        if (poke && n == 2) begin
          start   = 1'b1;
          opcode  = OP_AND;
          A       = 8'($urandom);
          B       = 8'($urandom);
          use_acc = 1'($urandom);
        end
        tick();
        start = 1'b0;
        n++;
      end
      check("mul_latency", 16'(n), 16'(W));
      check("mul_busy_end", 16'(busy), 16'd0);
    end else begin
      check("op_busy", 16'(busy), 16'd0);
    end
    check("done", 16'(done), 16'd1);
    check("saida", 16'(Saida), 16'(e[7:0]));
    check("flag_o", 16'(FLAG_O), 16'(e[11]));
    check("flag_c", 16'(FLAG_C), 16'(e[10]));
    check("flag_z", 16'(FLAG_Z), 16'(e[9]));
    check("flag_n", 16'(FLAG_N), 16'(e[8]));
    acc = e[7:0];
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {5'b0, busy, done, FLAG_O, FLAG_C, FLAG_Z, FLAG_N, 1'b0, 4'b0} | 16'(Saida), 16'd0);
  endtask

  initial begin
    int quiet;
    logic [2:0] rop;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; opcode = '0; use_acc = 1'b0; acc = '0;
    tick();
    tick();
    check_all_zero("reset_outputs");

    // rst wins over start
    start = 1'b1; opcode = OP_ADD; A = 8'h11; B = 8'h22;
    tick();
    start = 1'b0;
    check_all_zero("rst_over_start");
    rst = 1'b0;
    tick();
    check("idle_no_done", 16'(done), 16'd0);

    run_op(OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b0);
    check("add_7f01", {FLAG_O, FLAG_C, FLAG_Z, FLAG_N, 4'b0, Saida}, 16'h9080);
    run_op(OP_SUB, 8'h00, 8'h01, 1'b0, 1'b0);
    check("sub_0001", {FLAG_O, FLAG_C, FLAG_Z, FLAG_N, 4'b0, Saida}, 16'h50FF);
    run_op(OP_SUB, 8'h80, 8'h01, 1'b0, 1'b0);
    check("sub_8001", {FLAG_O, FLAG_C, 6'b0, Saida}, 16'h807F);
    run_op(OP_MUL, 8'h10, 8'h11, 1'b0, 1'b1);
    check("mul_1011", {FLAG_O, FLAG_C, 6'b0, Saida}, 16'h8010);
    tick();
    check("done_pulse", 16'(done), 16'd0);
    check("hold_after_mul", 16'(Saida), 16'h0010);

    run_op(OP_ADD, 8'h03, 8'h04, 1'b0, 1'b0);
    run_op(OP_ADD, 8'hEE, 8'h05, 1'b1, 1'b0);
    check("acc_add", 16'(Saida), 16'h000C);
    run_op(OP_CLR, 8'h55, 8'h66, 1'b0, 1'b0);
    check("clr", {FLAG_O, FLAG_C, FLAG_Z, FLAG_N, 4'b0, Saida}, 16'h2000);
    run_op(OP_SHL, 8'h81, 8'h01, 1'b0, 1'b0);
    check("shl_81", {FLAG_C, 7'b0, Saida}, 16'h8002);
    run_op(OP_SHL, 8'h5A, 8'h00, 1'b0, 1'b0);
    check("shl_zero", {FLAG_C, 7'b0, Saida}, 16'h005A);
    run_op(OP_AND, 8'hF0, 8'h0F, 1'b0, 1'b0);
    check("and_zero", {FLAG_Z, 7'b0, Saida}, 16'h8000);

    // Abort a multiply with reset part-way through
    run_op(OP_OR, 8'h33, 8'h44, 1'b0, 1'b0);
    start = 1'b1; opcode = OP_MUL; A = 8'hFF; B = 8'hFF; use_acc = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("mul_busy_pre_rst", 16'(busy), 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("mul_abort");
    acc = '0;
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) quiet++;
    end
    check("no_done_after_abort", 16'(quiet), 16'd0);
    run_op(OP_OR, 8'h0A, 8'h50, 1'b0, 1'b0);
    check("or_after_abort", 16'(Saida), 16'h005A);

    for (int i = 0; i < 80; i++) begin
      rop = 3'($urandom_range(0, 7));
      run_op(rop, 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        tick();
        check("rand_idle_done", 16'(done), 16'd0);
        check("rand_hold", 16'(Saida), 16'(acc));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
